// File: rtl/uart_bram_tx.sv
// uart_bram_tx: streams a block of bytes from a synchronous buffer (one-clock
// read latency) out of an 8N1 UART transmitter.
//
// Handshake: start is a single-cycle request sampled only while busy=0.
// Accepting it latches base_addr and len. busy stays high until the last stop
// bit has completed. done pulses for exactly one clock when the block
// finishes, including an empty block (len=0).
//
// Timeline for a block accepted at edge E0:
//   E0      raddr <= base_addr, state FETCH (buffer read in flight)
//   E1      state LOAD (rdata now valid for base_addr)
//   E2      shift register <= rdata, tx <= 0 (start bit), state START
//   then    START / DATA x8 / STOP, each held CLKS_PER_BIT clocks.
// While byte k is on the line, the next address is issued on the first data
// bit and the returned byte is parked in a holding register. The STOP->START
// transition then needs no buffer access, so frames go out back-to-back.
`timescale 1ns/1ps

module uart_bram_tx #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  // Bit-timing counter is just wide enough to hold CLKS_PER_BIT-1.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [2:0]       LAST_BIT   = 3'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH:0] ONE_LEFT = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] NONE     = '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [1:0]            pend_q, pend_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  bit_end;

  // Current bit period expires on this clock.
  assign bit_end = (cnt_q == '0);

  // Next-state, datapath and output computation for the transmit sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    raddr_d = raddr_q;
    rem_d   = rem_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    // pend tracks a prefetch: bit0 = address issued, bit1 = data arriving.
    pend_d  = {pend_q[0], 1'b0};

    // Prefetched byte is valid on rdata two clocks after its address.
    if (pend_q[1]) begin
      hold_d = rdata;
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (start) begin
          if (len == NONE) begin
            // Empty block: report completion without touching the line.
            done_d = 1'b1;
          end else begin
            raddr_d = base_addr;
            rem_d   = len;
            state_d = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        // Buffer read of base_addr is in flight.
        state_d = S_LOAD;
      end

      S_LOAD: begin
        shift_d = rdata;
        tx_d    = 1'b0;
        cnt_d   = BIT_RELOAD;
        state_d = S_START;
      end

      S_START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = 3'd0;
          cnt_d   = BIT_RELOAD;
          state_d = S_DATA;
          // Issue the next byte's address only if another byte follows.
          if (rem_q > ONE_LEFT) begin
            raddr_d   = raddr_q + 1'b1;
            pend_d[0] = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cnt_d = BIT_RELOAD;
          if (bit_q == LAST_BIT) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          if (rem_q == ONE_LEFT) begin
            tx_d    = 1'b1;
            done_d  = 1'b1;
            rem_d   = NONE;
            state_d = S_IDLE;
          end else begin
            // Next frame's start bit follows the stop bit with no gap.
            tx_d    = 1'b0;
            shift_d = hold_q;
            rem_d   = rem_q - ONE_LEFT;
            cnt_d   = BIT_RELOAD;
            state_d = S_START;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      raddr_q <= '0;
      rem_q   <= '0;
      pend_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      raddr_q <= raddr_d;
      rem_q   <= rem_d;
      pend_q  <= pend_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign raddr = raddr_q;
  assign tx    = tx_q;
  assign done  = done_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_bram_tx.sv
// Directed bench for uart_bram_tx with a 1-cycle-latency buffer model and a
// line monitor that decodes 8N1 frames and timestamps start bits.
`timescale 1ns/1ps

module tb_uart_bram_tx;

  localparam int AW = 6;
  localparam int C  = 4;
  localparam int FRAME = 10 * C;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic [AW-1:0] raddr;
  logic [7:0]    rdata;
  logic          tx;
  logic          busy;
  logic          done;

  uart_bram_tx #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(C)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .raddr    (raddr),
    .rdata    (rdata),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- buffer model ----------------
  logic [7:0] mem [64];
  always @(posedge clk) rdata <= mem[raddr];

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         starts_q[$];
  logic [AW-1:0] raddr_log[$];
  int         checks;
  int         failures;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- line monitor ----------------
  int         cyc;
  int         mon_st;
  int         mon_p;
  int         k;
  logic [7:0] mon_byte;
  int         done_cnt;
  int         done_cyc;
  int         busy_seen;
  int         frame_err;
  logic [AW-1:0] last_raddr;
  int         clr_gen;
  int         clr_seen;

  always @(negedge clk) begin
    cyc++;
    if (clr_gen != clr_seen) begin
      clr_seen = clr_gen;
      rx_q.delete();
      starts_q.delete();
      raddr_log.delete();
      done_cnt  = 0;
      done_cyc  = 0;
      busy_seen = 0;
      frame_err = 0;
      last_raddr = raddr;
    end
    if (!rst_n) begin
      mon_st = 0;
    end else begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_seen++;
      if (raddr != last_raddr) begin
        raddr_log.push_back(raddr);
        last_raddr = raddr;
      end
      if (mon_st == 0) begin
        if (tx == 1'b0) begin
          mon_st = 1;
          mon_p  = 0;
          starts_q.push_back(cyc);
        end
      end else begin
        mon_p++;
        if (mon_p % C == C / 2) begin
          k = mon_p / C;
          if (k == 0) begin
            if (tx !== 1'b0) frame_err++;
          end else if (k <= 8) begin
            mon_byte[k-1] = tx;
          end else begin
            if (tx !== 1'b1) frame_err++;
            rx_q.push_back(mon_byte);
            mon_st = 0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_monitor();
    clr_gen++;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Runs one block; poke>0 pulses a stray start that many clocks into it.
  task automatic run_block(input logic [AW-1:0] b, input int n, input int poke);
    logic got_done;
    int   bad_gaps;
    clear_monitor();
    base_addr = b;
    len       = 7'(n);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    base_addr = ~b;
    len       = 7'd33;
    check("e0_busy", 32'(busy), 32'(n > 0));
    check("e0_done", 32'(done), 32'(n == 0));
    if (n > 0) begin
      check("e0_raddr", 32'(raddr), 32'(b));
      @(negedge clk);
      check("e1_tx_high", 32'(tx), 32'd1);
      @(negedge clk);
      check("e2_tx_start", 32'(tx), 32'd0);
      got_done = 1'b0;
      for (int i = 1; i <= n * FRAME + 20 && !got_done; i++) begin
        @(negedge clk);
        if (poke > 0 && i == poke) begin
          start     = 1'b1;
          base_addr = 6'd0;
          len       = 7'd5;
        end else begin
          start = 1'b0;
        end
        if (done) got_done = 1'b1;
      end
      start = 1'b0;
      check("done_seen", 32'(got_done), 32'd1);
    end
    repeat (3) @(negedge clk);
    check("end_busy", 32'(busy), 32'd0);
    check("end_tx", 32'(tx), 32'd1);
    check("end_done", 32'(done), 32'd0);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("frames", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < rx_q.size(); j++) begin
      check("rx_byte", 32'(rx_q[j]), 32'(exp_q[j]));
    end
    if (n > 0) begin
      check("frame_err", 32'(frame_err), 32'd0);
      check("line_time", (starts_q.size() > 0) ? 32'(done_cyc - starts_q[0]) : 32'hffff_ffff,
            32'(n * FRAME));
      bad_gaps = 0;
      for (int j = 1; j < starts_q.size(); j++) begin
        if (starts_q[j] - starts_q[j-1] != FRAME) bad_gaps++;
      end
      check("frame_gaps", 32'(bad_gaps), 32'd0);
    end else begin
      check("len0_busy", 32'(busy_seen), 32'd0);
      check("len0_no_start", 32'(starts_q.size()), 32'd0);
    end
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks    = 0;
    failures  = 0;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    rst_n     = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_raddr", 32'(raddr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte 0xA5 from address 5.
    mem[5] = 8'hA5;
    exp_q.push_back(8'hA5);
    run_block(6'd5, 1, 0);

    // Three bytes across the address wrap.
    mem[62] = 8'h11;
    mem[63] = 8'h22;
    mem[0]  = 8'h33;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    run_block(6'd62, 3, 0);
    check("raddr_log_len", 32'(raddr_log.size()), 32'd3);
    if (raddr_log.size() == 3) begin
      check("raddr_0", 32'(raddr_log[0]), 32'd62);
      check("raddr_1", 32'(raddr_log[1]), 32'd63);
      check("raddr_2", 32'(raddr_log[2]), 32'd0);
    end

    // Empty block.
    run_block(6'd7, 0, 0);

    // Stray start during the first byte of a two-byte block.
    mem[20] = 8'h3C;
    mem[21] = 8'hC3;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    run_block(6'd20, 2, 12);

    // Reset during data bit 3 of a frame.
    clear_monitor();
    base_addr = 6'd20;
    len       = 7'd2;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    repeat (17) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_tx", 32'(tx), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_raddr", 32'(raddr), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("arst_no_done", 32'(done_cnt), 32'd0);
    check("arst_idle_tx", 32'(tx), 32'd1);
    exp_q.push_back(8'hC3);
    run_block(6'd21, 1, 0);

    // Full buffer from address 10.
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    for (int i = 0; i < 64; i++) exp_q.push_back(8'((10 + i) % 64));
    run_block(6'd10, 64, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
